// File: rtl/vga_sync_decoder.sv
// Receive-side video timing decoder: measures hs period and frame height from an
// incoming raster, locks onto it, and regenerates active-pixel coordinates.
module vga_sync_decoder #(
  parameter int          LOCK_FRAMES = 2,
  parameter logic [10:0] MAX_PERIOD  = 11'd2047
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        hs,
  input  logic        vs,
  input  logic        blank,
  output logic [10:0] PixelX,
  output logic [10:0] PixelY,
  output logic        PixelValid,
  output logic [10:0] LineLen,
  output logic [10:0] FrameLines,
  output logic        Locked,
  output logic        SyncErr
);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  match_reg, match_next;
  logic [10:0] ref_lines_reg, ref_lines_next;
  logic [10:0] ref_len_reg, ref_len_next;
  logic        locked_next, sync_err_next;

  logic        hs_q, vs_q, blank_q;
  logic [10:0] per, line_cnt, first_len;
  logic        have_first, frame_ok;

  logic        hs_fall, vs_fall, blk_rise, blk_fall;
  logic [10:0] per_inc, frame_lines_new, cur_len;
  logic        per_sat, fault;

  assign hs_fall         = hs_q & ~hs;
  assign vs_fall         = vs_q & ~vs;
  assign blk_rise        = ~blank_q & blank;
  assign blk_fall        = blank_q & ~blank;
  assign per_inc         = per + 11'd1;
  assign per_sat         = (per == MAX_PERIOD);
  assign frame_lines_new = line_cnt + {10'd0, hs_fall};
  // Length of the most recent line, including one completing on this very cycle
  assign cur_len         = hs_fall ? per_inc : LineLen;

  assign fault = (state_reg == LOCKED) &
                 ((hs_fall & (per_inc != ref_len_reg)) |
                  (vs_fall & (frame_lines_new != ref_lines_reg)) |
                  per_sat);

  assign PixelValid = blank_q & Locked;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      blank_q    <= 1'b1;
      per        <= '0;
      line_cnt   <= '0;
      first_len  <= '0;
      have_first <= 1'b0;
      frame_ok   <= 1'b0;
      LineLen    <= '0;
      FrameLines <= '0;
      PixelX     <= '0;
      PixelY     <= '0;
    end else begin
      hs_q    <= hs;
      vs_q    <= vs;
      blank_q <= blank;

      if (hs_fall)      per <= '0;
      else if (!per_sat) per <= per_inc;

      if (hs_fall) begin
        LineLen  <= per_inc;
        line_cnt <= line_cnt + 11'd1;
      end
      if (vs_fall) begin
        FrameLines <= frame_lines_new;
        line_cnt   <= '0;
      end

      // Frame is clean only if every line matches the first line seen after vs
      if (vs_fall) begin
        frame_ok   <= 1'b1;
        have_first <= 1'b0;
      end else begin
        if (hs_fall) begin
          if (!have_first) begin
            first_len  <= per_inc;
            have_first <= 1'b1;
          end else if (per_inc != first_len) begin
            frame_ok <= 1'b0;
          end
        end
        if (per_sat) frame_ok <= 1'b0;
      end

      if (blk_rise)     PixelX <= '0;
      else if (blank_q) PixelX <= PixelX + 11'd1;

      if (vs_fall)       PixelY <= '0;
      else if (blk_fall) PixelY <= PixelY + 11'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_reg     <= SEARCH;
      match_reg     <= '0;
      ref_lines_reg <= '0;
      ref_len_reg   <= '0;
      Locked        <= 1'b0;
      SyncErr       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      match_reg     <= match_next;
      ref_lines_reg <= ref_lines_next;
      ref_len_reg   <= ref_len_next;
      Locked        <= locked_next;
      SyncErr       <= sync_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    match_next     = match_reg;
    ref_lines_next = ref_lines_reg;
    ref_len_next   = ref_len_reg;
    locked_next    = Locked;
    sync_err_next  = 1'b0;
    case (state_reg)
      SEARCH: begin
        if (vs_fall) begin
          state_next     = ACQUIRE;
          match_next     = '0;
          ref_lines_next = '0;
        end
      end
      ACQUIRE: begin
        if (vs_fall) begin
          ref_lines_next = frame_lines_new;
          if (frame_ok && (frame_lines_new == ref_lines_reg)) begin
            match_next = match_reg + 4'd1;
            if ((match_reg + 4'd1) == 4'(LOCK_FRAMES)) begin
              state_next   = LOCKED;
              locked_next  = 1'b1;
              ref_len_next = cur_len;
            end
          end else begin
            match_next = '0;
          end
        end
      end
      LOCKED: begin
        if (fault) begin
          state_next    = SEARCH;
          match_next    = '0;
          locked_next   = 1'b0;
          sync_err_next = 1'b1;
        end
      end
      default: state_next = SEARCH;
    endcase
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a reduced raster (64-clock lines,
// 12-line frames) so every scenario fits in a short run.
module tb_vga_sync_decoder;

  localparam int L        = 64;
  localparam int HS_START = 50;
  localparam int HS_W     = 8;
  localparam int HACT     = 40;
  localparam int VACT     = 8;
  localparam int VS_LINE  = 9;
  localparam int NL       = 12;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        hs = 1'b1;
  logic        vs = 1'b1;
  logic        blank = 1'b0;
  logic [10:0] PixelX, PixelY, LineLen, FrameLines;
  logic        PixelValid, Locked, SyncErr;

  vga_sync_decoder dut (
    .Clk(Clk), .Reset(Reset), .hs(hs), .vs(vs), .blank(blank),
    .PixelX(PixelX), .PixelY(PixelY), .PixelValid(PixelValid),
    .LineLen(LineLen), .FrameLines(FrameLines), .Locked(Locked), .SyncErr(SyncErr)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  int   prev_h = 0, prev_line = 0;
  logic prev_b = 1'b0, prev_rst = 1'b0, prev_locked = 1'b0;
  logic px_chk = 1'b0;
  int   vsf_cnt = 0, cyc_since_vsf = 0, rise_vs = 0, rise_dly = 0;
  int   err_cnt = 0, err_lock_cnt = 0, lock_cyc = 0;

  // One clock: sample the outputs produced by the previous drive, then drive anew
  task automatic step(input logic h_i, input logic v_i, input logic b_i,
                      input logic rst_i, input int line, input int h);
    @(negedge Clk);
    cyc_since_vsf++;
    if (SyncErr) begin
      err_cnt++;
      if (Locked) err_lock_cnt++;
    end
    if (Locked) lock_cyc++;
    if (Locked && !prev_locked) begin
      rise_vs  = vsf_cnt;
      rise_dly = cyc_since_vsf;
    end
    prev_locked = Locked;
    if (prev_rst) begin
      check("rst_pixelx", PixelX, 0);
      check("rst_pixely", PixelY, 0);
      check("rst_valid", PixelValid, 0);
      check("rst_linelen", LineLen, 0);
      check("rst_framelines", FrameLines, 0);
      check("rst_locked", Locked, 0);
      check("rst_syncerr", SyncErr, 0);
    end
    if (px_chk) begin
      check("px_valid", PixelValid, prev_b);
      if (prev_b) begin
        check("px_x", PixelX, prev_h);
        check("px_y", PixelY, prev_line);
      end
    end
    if (rst_i) vsf_cnt = 0;
    else if (vs && !v_i) begin
      vsf_cnt++;
      cyc_since_vsf = 0;
    end
    hs        = h_i;
    vs        = v_i;
    blank     = b_i;
    Reset     = ~rst_i;
    prev_h    = h;
    prev_line = line;
    prev_b    = b_i;
    prev_rst  = rst_i;
  endtask

  task automatic run_frame(input int nl, input int short_l, input int stuck_l, input int rst_l);
    int   len;
    logic h_v, v_v, b_v, r_v;
    for (int l = 0; l < nl; l++) begin
      len = (l == short_l) ? L - 1 : ((l == stuck_l) ? 2100 : L);
      for (int x = 0; x < len; x++) begin
        h_v = (l == stuck_l) ? 1'b1 : !(x >= HS_START && x < HS_START + HS_W);
        v_v = (l != VS_LINE);
        b_v = (x < HACT) && (l < VACT);
        r_v = (l == rst_l) && (x == 10);
        step(h_v, v_v, b_v, r_v, l, x);
      end
    end
  endtask

  initial begin
    step(1'b1, 1'b1, 1'b0, 1'b1, 0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 0, 0);

    // Nominal raster: lock on the 4th vs fall, then check coordinates for a full frame
    err_cnt = 0;
    for (int f = 0; f < 4; f++) run_frame(NL, -1, -1, -1);
    px_chk = 1'b1;
    run_frame(NL, -1, -1, -1);
    px_chk = 1'b0;
    check("nom_lock_vs", rise_vs, 4);
    check("nom_lock_dly", rise_dly, 1);
    check("nom_syncerr", err_cnt, 0);
    check("nom_linelen", LineLen, L);
    check("nom_framelines", FrameLines, NL);
    check("nom_locked", Locked, 1);

    // One short line while locked
    err_cnt = 0; err_lock_cnt = 0; vsf_cnt = 0; rise_vs = 0;
    run_frame(NL, 3, -1, -1);
    check("short_pulses", err_cnt, 1);
    check("short_err_with_lock", err_lock_cnt, 0);
    check("short_unlocked", Locked, 0);
    for (int f = 0; f < 3; f++) run_frame(NL, -1, -1, -1);
    check("short_relock", Locked, 1);
    check("short_relock_vs", rise_vs, 4);
    check("short_relock_dly", rise_dly, 1);
    check("short_total_pulses", err_cnt, 1);

    // hs stuck high long enough to saturate the period counter
    err_cnt = 0; err_lock_cnt = 0;
    run_frame(NL, -1, 3, -1);
    check("stuck_pulses", err_cnt, 1);
    check("stuck_err_with_lock", err_lock_cnt, 0);
    check("stuck_unlocked", Locked, 0);

    // Alternating frame heights never lock
    err_cnt = 0; lock_cyc = 0;
    for (int f = 0; f < 6; f++) run_frame((f % 2 == 0) ? NL + 1 : NL, -1, -1, -1);
    check("alt_pulses", err_cnt, 0);
    check("alt_locked_cycles", lock_cyc, 0);

    // Back to a steady raster, then reset mid-frame while locked
    for (int f = 0; f < 3; f++) run_frame(NL, -1, -1, -1);
    check("pre_reset_locked", Locked, 1);
    err_cnt = 0; rise_vs = 0;
    run_frame(NL, -1, -1, 4);
    for (int f = 0; f < 3; f++) run_frame(NL, -1, -1, -1);
    check("reset_relock", Locked, 1);
    check("reset_relock_vs", rise_vs, 4);
    check("reset_relock_dly", rise_dly, 1);
    check("reset_pulses", err_cnt, 0);
    check("reset_framelines", FrameLines, NL);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the video timing generator: consumes active-low hs/vs and the active-high display-enable (blank) stream.
- Measures line length and frame height, and locks onto a stable raster.
- Regenerates PixelX/PixelY coordinates, so capture/line-buffer logic can sit downstream of any sync source.

Parameters:
LOCK_FRAMES, 2, consecutive matching clean frames required to declare lock
MAX_PERIOD, 11'd2047, hs period counter saturation value; reaching it counts as sync loss

Ports:
Clk  input  1  pixel clock
Reset  input  1  synchronous, active-low reset
hs  input  1  horizontal sync, active low
vs  input  1  vertical sync, active low
blank  input  1  display enable, 1 = active pixel
PixelX  output  11  active-pixel column index
PixelY  output  11  active-line row index
PixelValid  output  1  registered blank, gated by Locked
LineLen  output  11  last measured hs period in clocks
FrameLines  output  11  hs falls counted in the last complete frame
Locked  output  1  raster stable
SyncErr  output  1  one-cycle pulse on loss of lock

Behaviour:
- Reset (Reset==0 at a Clk edge): all outputs 0; internal counters 0; state SEARCH; input sample registers set to 1 (idle sync level).
- Input stage: hs_q, vs_q, blank_q are registered each cycle.
  - hs_fall = hs_q & ~hs; vs_fall = vs_q & ~vs.
  - blk_rise = ~blank_q & blank; blk_fall = blank_q & ~blank.
- Period counter per:
  - 0 on an hs_fall cycle; otherwise +1, saturating at MAX_PERIOD.
  - On hs_fall: LineLen <= per+1; line_cnt <= line_cnt+1.
- Line counter line_cnt:
  - On vs_fall: FrameLines <= line_cnt (+1 if hs_fall occurs in the same cycle); line_cnt <= 0.
- X generation:
  - PixelX <= 0 on the cycle after blk_rise.
  - Increments each cycle while blank_q==1.
  - Holds its value while blanked.
- Y generation:
  - PixelY <= 0 on vs_fall.
  - Increments on blk_fall (end of each active line).
  - vs_fall wins if both occur in the same cycle.
- Latency: PixelValid/PixelX/PixelY are one cycle after the corresponding blank sample.
  - First active pixel of a line: PixelValid=1, PixelX=0.
- Line-clean flag frame_ok:
  - Set at vs_fall.
  - Cleared if any hs_fall within the frame yields per+1 != the first LineLen of that frame.
  - Cleared if per reaches MAX_PERIOD.
- State machine:
  - SEARCH: wait for vs_fall, then go to ACQUIRE with match=0 and ref_lines=0.
  - ACQUIRE, at each vs_fall:
    - if frame_ok and FrameLines_new==ref_lines: match <= match+1, else match <= 0;
    - ref_lines <= FrameLines_new.
    - When match reaches LOCK_FRAMES: go to LOCKED; Locked=1 from the next cycle; store ref_len=LineLen.
  - LOCKED, fault conditions:
    - hs_fall with per+1 != ref_len;
    - vs_fall with FrameLines_new != ref_lines;
    - per reaching MAX_PERIOD.
    - Any fault: SyncErr=1 for exactly one cycle, Locked=0 the same cycle, state -> SEARCH, match cleared.
  - Simultaneous fault conditions produce a single SyncErr pulse.
- PixelValid = blank_q & Locked. PixelX/PixelY keep counting regardless of lock.
- Widths: all counters are 11 bits.
  - PixelX/PixelY wrap modulo 2048; no error is raised.
  - per saturates and does not wrap.
- Reset asserted mid-frame: immediate return to the reset state on that edge; re-lock needs a full reacquire.

Test Plan:
- Nominal raster (line 341 clocks, hs low 41 clocks at h=280, frame 524 lines, vs low 1 line at line 490, blank high h<255 & line<480, run 5 frames) -> LineLen=341, FrameLines=524, Locked=1 on the cycle after the 4th vs_fall, SyncErr=0.
- Locked raster, active region -> PixelValid high 255 cycles per line, PixelX 0..254, PixelY 0..479, PixelY=0 on the first active line after vs_fall.
- Locked, one line shortened to 340 clocks -> SyncErr pulses one cycle at that hs_fall, Locked=0, relock after 4 more clean frames (3 of them matching).
- Locked, hs held high for 2100 clocks -> per saturates at 2047, SyncErr one pulse, state SEARCH, no further pulses while hs is stuck.
- Frame heights alternating 524/525 -> match never reaches 2, Locked stays 0, SyncErr never asserts.
- Reset=0 for one cycle mid-frame while Locked -> all outputs 0 next cycle, relock after 4 vs_falls.
